i2c_req_arbiter: RTL

- Shares the single I2C master port of the memory subsystem among `NUM_REQ` requesters (CPU bridge, memory controller, test engine, …).
- Arbitrates round-robin and latches the winner's command.
- Sequences exactly one start/done transaction on the master, then returns read data and ACK status to the winner only.
- Sits between the requesters and the I2C master instance, in the same clock domain.

---
 rtl/i2c_req_arbiter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter
//   Shares one I2C master port among NUM_REQ requesters. A round-robin pick
//   in IDLE latches the winner's command into the m_* registers. Exactly one
//   start/done transaction runs on the master. The read data and ACK status
//   then return to the winner alone as a one-cycle done pulse.
//
//   Every output comes from a register, so no input reaches an output
//   combinationally.
//
//   Optional feature: define I2C_ARB_TIMEOUT_EN to build a watchdog on the WAIT
//   state. Without it, WAIT is unbounded and m_abort/rsp_timeout stay 0.
//
// Parameters
//   NUM_REQ        number of requesters (2..8)
//   TIMEOUT_CYCLES watchdog limit in WAIT (timeout build only)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req/req_write            per-requester request level and direction (1 = write)
//   req_slave_addr           packed 7-bit slave addresses, requester i at [7i+6:7i]
//   req_addr/req_wdata       packed 8-bit register address / write data
//   gnt                      one-hot grant, held for the whole transaction
//   done                     one-cycle completion pulse to the granted requester
//   rsp_rdata/nack/timeout   response fields, valid with done, held afterwards
//   m_start/m_abort          one-cycle command / abort strobes to the master
//   m_write..m_wdata         latched command fields
//   m_busy/m_done/m_ack/m_rdata  status from the master
module i2c_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_write,
  input  logic [7*NUM_REQ-1:0] req_slave_addr,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_nack,
  output logic                 rsp_timeout,
  output logic                 m_start,
  output logic                 m_write,
  output logic [6:0]           m_slave_addr,
  output logic [7:0]           m_addr,
  output logic [7:0]           m_wdata,
  output logic                 m_abort,
  input  logic                 m_busy,
  input  logic                 m_done,
  input  logic                 m_ack,
  input  logic [7:0]           m_rdata
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic               start_q, start_d;
  logic               wr_q, wr_d;
  logic [6:0]         sa_q, sa_d;
  logic [7:0]         ad_q, ad_d, wd_q, wd_d, rdata_q, rdata_d;
  logic               nack_q, nack_d, tmo_q, tmo_d;

  // Round-robin pick: walk from ptr upward with wrap-around. The loop runs
  // downward so that the candidate closest to ptr is the last one written.
  logic [PW:0]        rr_sum;
  logic [PW-1:0]      rr_idx, rr_win;

  always_comb begin : rr_pick
    rr_sum = '0;
    rr_idx = '0;
    rr_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (rr_sum >= (PW+1)'(NUM_REQ)) rr_sum = rr_sum - (PW+1)'(NUM_REQ);
      rr_idx = rr_sum[PW-1:0];
      if (req[rr_idx]) rr_win = rr_idx;
    end
  end

  // Command fields and grant vector of the chosen requester.
  logic               sel_wr;
  logic [6:0]         sel_sa;
  logic [7:0]         sel_ad, sel_wd;
  logic [NUM_REQ-1:0] sel_onehot;

  always_comb begin : field_mux
    sel_wr     = 1'b0;
    sel_sa     = '0;
    sel_ad     = '0;
    sel_wd     = '0;
    sel_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_win == PW'(i)) begin
        sel_wr        = req_write[i];
        sel_sa        = req_slave_addr[7*i +: 7];
        sel_ad        = req_addr[8*i +: 8];
        sel_wd        = req_wdata[8*i +: 8];
        sel_onehot[i] = 1'b1;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          limit;

  // The abort strobe is decoded from the counter alone, which keeps it
  // registered. If m_done lands in that same cycle, the completion is still
  // reported as a normal one.
  assign limit   = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign m_abort = limit;

  always_comb begin : wdog_next
    cnt_d = cnt_q;
    if (state_q == S_ISSUE)     cnt_d = '0;
    else if (state_q == S_WAIT) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  // The timeout limit only matters in the watchdog build.
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
  assign m_abort    = 1'b0;
`endif

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    start_d = 1'b0;
    wr_d    = wr_q;
    sa_d    = sa_q;
    ad_d    = ad_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    nack_d  = nack_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d   = rr_win;
          gnt_d   = sel_onehot;
          wr_d    = sel_wr;
          sa_d    = sel_sa;
          ad_d    = sel_ad;
          wd_d    = sel_wd;
          // The strobe is registered, so it fires one cycle after m_busy is low.
          start_d = ~m_busy;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (start_q) state_d = S_WAIT;
        else         start_d = ~m_busy;
      end
      S_WAIT: begin
        if (m_done) begin
          nack_d  = ~m_ack;
          rdata_d = wr_q ? 8'h00 : m_rdata;
          tmo_d   = 1'b0;
          done_d  = gnt_q;
          state_d = S_RESP;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (limit) begin
          nack_d  = 1'b1;
          rdata_d = 8'h00;
          tmo_d   = 1'b1;
          done_d  = gnt_q;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP: begin
        gnt_d   = '0;
        ptr_d   = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + PW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      wr_q    <= 1'b0;
      sa_q    <= '0;
      ad_q    <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      nack_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      start_q <= start_d;
      wr_q    <= wr_d;
      sa_q    <= sa_d;
      ad_q    <= ad_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      nack_q  <= nack_d;
      tmo_q   <= tmo_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_q;
  assign m_start      = start_q;
  assign m_write      = wr_q;
  assign m_slave_addr = sa_q;
  assign m_addr       = ad_q;
  assign m_wdata      = wd_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_nack     = nack_q;
  assign rsp_timeout  = tmo_q;

endmodule
